// File: rtl/alt_vipitc130_sync_pkg.sv
// Shared limits and helpers for the synchroniser / glitch-filter slice.
// Used by alt_vipitc130_sync_bit_filter and alt_vipitc130_common_sync_filt.
package alt_vipitc130_sync_pkg;

   localparam int STAGES_MIN     = 2;
   localparam int STAGES_MAX     = 8;
   localparam int FILTER_LEN_MAX = 256;
   localparam int WIDTH_MAX      = 64;

   // Counter must hold FILTER_LEN-1 and never be zero-width.
   function automatic int cnt_width(input int len);
      return (len <= 2) ? 1 : $clog2(len);
   endfunction

endpackage

// File: rtl/alt_vipitc130_sync_bit_filter.sv
// One bit: synchroniser chain, stability counter, filtered output, edge pulses.
// Edge pulses exist only when ALT_VIPITC130_SYNC_EDGE_DET_EN is defined.
module alt_vipitc130_sync_bit_filter
   import alt_vipitc130_sync_pkg::*;
#(
   parameter int CLOCKS_ARE_SAME = 0,
   parameter int STAGES          = 2,
   parameter int FILTER_LEN      = 1
) (
   input  logic sync_clock,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall,
   output logic o_accept
);

   localparam int CW = cnt_width(FILTER_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic          w_s;
   logic          w_accept;
   logic          r_q;
   logic [CW-1:0] r_cnt;

   generate
      if (CLOCKS_ARE_SAME < 0 || CLOCKS_ARE_SAME > 1) begin : g_bad_same
         $error("CLOCKS_ARE_SAME must be 0 or 1");
      end
      if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
         $error("STAGES out of range 2..8");
      end
      if (FILTER_LEN < 1 || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_len
         $error("FILTER_LEN out of range 1..256");
      end
   endgenerate

   generate
      if (CLOCKS_ARE_SAME != 0) begin : g_bypass
         assign w_s = i_d;
      end else begin : g_chain
         (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
         logic [STAGES-1:0] r_chain;

         always_ff @(posedge sync_clock or negedge rst_n) begin
            if (!rst_n) begin
               r_chain <= '0;
            end else begin
               r_chain <= {r_chain[STAGES-2:0], i_d};
            end
         end

         assign w_s = r_chain[STAGES-1];
      end
   endgenerate

   // A change is taken only after FILTER_LEN consecutive differing samples.
   assign w_accept = (w_s != r_q) && (r_cnt == CNT_LAST);

   always_ff @(posedge sync_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= 1'b0;
         r_cnt <= '0;
      end else if (w_s == r_q) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_q   <= w_s;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_q      = r_q;
   assign o_accept = w_accept;

`ifdef ALT_VIPITC130_SYNC_EDGE_DET_EN
   logic r_rise;
   logic r_fall;

   always_ff @(posedge sync_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_accept & w_s;
         r_fall <= w_accept & ~w_s;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/alt_vipitc130_common_sync_filt.sv
// WIDTH independent synchronised, glitch-filtered level inputs.
// Edge pulses and changed built only with ALT_VIPITC130_SYNC_EDGE_DET_EN.
module alt_vipitc130_common_sync_filt
   import alt_vipitc130_sync_pkg::*;
#(
   parameter int CLOCKS_ARE_SAME = 0,
   parameter int WIDTH           = 1,
   parameter int STAGES          = 2,
   parameter int FILTER_LEN      = 1
) (
   input  logic             sync_clock,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             changed
);

   logic [WIDTH-1:0] w_accept;

   generate
      if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
         $error("WIDTH out of range 1..64");
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         alt_vipitc130_sync_bit_filter #(
            .CLOCKS_ARE_SAME (CLOCKS_ARE_SAME),
            .STAGES          (STAGES),
            .FILTER_LEN      (FILTER_LEN)
         ) u_bit (
            .sync_clock (sync_clock),
            .rst_n      (rst_n),
            .i_d        (data_in[gi]),
            .o_q        (data_out[gi]),
            .o_rise     (rise_pulse[gi]),
            .o_fall     (fall_pulse[gi]),
            .o_accept   (w_accept[gi])
         );
      end
   endgenerate

`ifdef ALT_VIPITC130_SYNC_EDGE_DET_EN
   logic r_changed;

   always_ff @(posedge sync_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |w_accept;
      end
   end

   assign changed = r_changed;
`else
   logic w_unused_accept;

   assign w_unused_accept = |w_accept;
   assign changed         = 1'b0;
`endif

endmodule

// File: tb/tb_alt_vipitc130_common_sync_filt.sv
// Bench: five configurations driven from one stimulus bus, checked against
// a window-based model of sync delay plus N-consecutive-sample filtering.
module tb_alt_vipitc130_common_sync_filt;

`ifdef ALT_VIPITC130_SYNC_EDGE_DET_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   localparam int NI = 5;
   localparam int ST [NI] = '{2, 3, 2, 2, 2};
   localparam int FL [NI] = '{1, 4, 2, 8, 1};
   localparam int SAME [NI] = '{0, 0, 0, 0, 1};
   localparam logic [3:0] MASK [NI] = '{4'h1, 4'h1, 4'hF, 4'h3, 4'h1};

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] din;
   logic armed = 1'b0;

   always #5 clk = ~clk;

   logic       d0, r0, f0, c0;
   logic       d1, r1, f1, c1;
   logic [3:0] d2, r2, f2;
   logic       c2;
   logic [1:0] d3, r3, f3;
   logic       c3;
   logic       d4, r4, f4, c4;

   alt_vipitc130_common_sync_filt #(
      .CLOCKS_ARE_SAME(0), .WIDTH(1), .STAGES(2), .FILTER_LEN(1)
   ) u0 (
      .sync_clock(clk), .rst_n(rst_n), .data_in(din[0]),
      .data_out(d0), .rise_pulse(r0), .fall_pulse(f0), .changed(c0)
   );

   alt_vipitc130_common_sync_filt #(
      .CLOCKS_ARE_SAME(0), .WIDTH(1), .STAGES(3), .FILTER_LEN(4)
   ) u1 (
      .sync_clock(clk), .rst_n(rst_n), .data_in(din[0]),
      .data_out(d1), .rise_pulse(r1), .fall_pulse(f1), .changed(c1)
   );

   alt_vipitc130_common_sync_filt #(
      .CLOCKS_ARE_SAME(0), .WIDTH(4), .STAGES(2), .FILTER_LEN(2)
   ) u2 (
      .sync_clock(clk), .rst_n(rst_n), .data_in(din),
      .data_out(d2), .rise_pulse(r2), .fall_pulse(f2), .changed(c2)
   );

   alt_vipitc130_common_sync_filt #(
      .CLOCKS_ARE_SAME(0), .WIDTH(2), .STAGES(2), .FILTER_LEN(8)
   ) u3 (
      .sync_clock(clk), .rst_n(rst_n), .data_in(din[1:0]),
      .data_out(d3), .rise_pulse(r3), .fall_pulse(f3), .changed(c3)
   );

   alt_vipitc130_common_sync_filt #(
      .CLOCKS_ARE_SAME(1), .WIDTH(1), .STAGES(2), .FILTER_LEN(1)
   ) u4 (
      .sync_clock(clk), .rst_n(rst_n), .data_in(din[0]),
      .data_out(d4), .rise_pulse(r4), .fall_pulse(f4), .changed(c4)
   );

   logic [3:0] a_out [NI];
   logic [3:0] a_rise [NI];
   logic [3:0] a_fall [NI];
   logic       a_chg [NI];

   always_comb begin
      a_out[0] = {3'b0, d0}; a_rise[0] = {3'b0, r0};
      a_fall[0] = {3'b0, f0}; a_chg[0] = c0;
      a_out[1] = {3'b0, d1}; a_rise[1] = {3'b0, r1};
      a_fall[1] = {3'b0, f1}; a_chg[1] = c1;
      a_out[2] = d2; a_rise[2] = r2;
      a_fall[2] = f2; a_chg[2] = c2;
      a_out[3] = {2'b0, d3}; a_rise[3] = {2'b0, r3};
      a_fall[3] = {2'b0, f3}; a_chg[3] = c3;
      a_out[4] = {3'b0, d4}; a_rise[4] = {3'b0, r4};
      a_fall[4] = {3'b0, f4}; a_chg[4] = c4;
   end

   // Model: hist[k][0] is data_in at this edge; the filter sees data_in
   // delayed by the chain depth, and flips a bit once the last FL views
   // of it all disagree with the current output.
   logic [3:0] hist [NI][32];
   logic [3:0] m_out [NI];
   logic [3:0] m_rise [NI];
   logic [3:0] m_fall [NI];
   logic       m_chg [NI];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 32; i++) hist[k][i] = 4'h0;
            m_out[k] = 4'h0;
            m_rise[k] = 4'h0;
            m_fall[k] = 4'h0;
            m_chg[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            int d;
            bit all;
            logic [3:0] mk;
            mk = MASK[k];
            for (int i = 31; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = din & mk;
            d = (SAME[k] != 0) ? 0 : ST[k];
            m_rise[k] = 4'h0;
            m_fall[k] = 4'h0;
            for (int b = 0; b < 4; b++) begin
               if (mk[b]) begin
                  all = 1'b1;
                  for (int j = 0; j < FL[k]; j++)
                     if (hist[k][d+j][b] == m_out[k][b]) all = 1'b0;
                  if (all) begin
                     m_out[k][b] = ~m_out[k][b];
                     if (m_out[k][b]) m_rise[k][b] = 1'b1;
                     else m_fall[k][b] = 1'b1;
                  end
               end
            end
            m_chg[k] = |{m_rise[k], m_fall[k]};
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < NI; k++) begin
            logic [3:0] er, ef;
            logic ec;
            er = EDGE_EN ? m_rise[k] : 4'h0;
            ef = EDGE_EN ? m_fall[k] : 4'h0;
            ec = EDGE_EN ? m_chg[k] : 1'b0;
            n_cmp++;
            if (a_out[k] !== m_out[k] || a_rise[k] !== er ||
                a_fall[k] !== ef || a_chg[k] !== ec) begin
               n_bad++;
               $display("FAIL model_u%0d t=%0t out=%h/%h rise=%h/%h fall=%h/%h chg=%b/%b (got/want)",
                        k, $time, a_out[k], m_out[k], a_rise[k], er,
                        a_fall[k], ef, a_chg[k], ec);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [3:0] act,
                        input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      din = 4'h0;
      edges(2);
      rst_n = 1'b1;
   endtask

   logic [3:0] vals [12] = '{4'h5, 4'h0, 4'hF, 4'hE, 4'h1, 4'h3,
                             4'h0, 4'h8, 4'h9, 4'h6, 4'hF, 4'h0};
   int holds [12] = '{1, 9, 2, 5, 12, 1, 3, 7, 10, 2, 6, 14};

   initial begin
      rst_n = 1'b1;
      din = 4'h0;
      #1 rst_n = 1'b0;
      armed = 1'b1;
      edges(2);
      check("rst_out_u2", a_out[2], 4'h0);
      check("rst_chg_u2", {3'b0, a_chg[2]}, 4'h0);
      rst_n = 1'b1;

      // single-bit latency, same-clock bypass, long filter latency
      din = 4'h1;
      edges(1);
      check("a_u4_out_e1", a_out[4], 4'h1);
      check("a_u4_rise_e1", a_rise[4], {3'b0, EDGE_EN});
      check("a_u0_out_e1", a_out[0], 4'h0);
      edges(2);
      check("a_u0_out_e3", a_out[0], 4'h1);
      check("a_u0_rise_e3", a_rise[0], {3'b0, EDGE_EN});
      check("a_u0_chg_e3", {3'b0, a_chg[0]}, {3'b0, EDGE_EN});
      edges(1);
      check("a_u0_rise_e4", a_rise[0], 4'h0);
      edges(2);
      check("a_u1_out_e6", a_out[1], 4'h0);
      edges(1);
      check("a_u1_out_e7", a_out[1], 4'h1);

      // short glitch rejected, qualifying pulse accepted
      do_reset();
      din = 4'h1;
      edges(3);
      din = 4'h0;
      edges(10);
      check("b_u1_glitch_out", a_out[1], 4'h0);
      din = 4'h1;
      edges(4);
      din = 4'h0;
      edges(2);
      check("b_u1_out_e6", a_out[1], 4'h0);
      edges(1);
      check("b_u1_out_e7", a_out[1], 4'h1);
      edges(3);
      check("b_u1_out_e10", a_out[1], 4'h1);
      edges(1);
      check("b_u1_out_e11", a_out[1], 4'h0);
      check("b_u1_fall_e11", a_fall[1], {3'b0, EDGE_EN});

      // multi-bit simultaneous edges
      do_reset();
      din = 4'hA;
      edges(3);
      check("c_u2_out_e3", a_out[2], 4'h0);
      edges(1);
      check("c_u2_out_e4", a_out[2], 4'hA);
      check("c_u2_rise_e4", a_rise[2], EDGE_EN ? 4'hA : 4'h0);
      check("c_u2_chg_e4", {3'b0, a_chg[2]}, {3'b0, EDGE_EN});
      edges(1);
      check("c_u2_rise_e5", a_rise[2], 4'h0);
      din = 4'h0;
      edges(4);
      check("c_u2_out_fall", a_out[2], 4'h0);
      check("c_u2_fall", a_fall[2], EDGE_EN ? 4'hA : 4'h0);

      // reset mid-count abandons the pending change
      do_reset();
      din = 4'h3;
      edges(7);
      check("d_u0_pre_rst", a_out[0], 4'h1);
      rst_n = 1'b0;
      #1;
      check("d_u0_rst_now", a_out[0], 4'h0);
      check("d_u2_rst_now", a_out[2], 4'h0);
      check("d_u3_rst_now", a_out[3], 4'h0);
      edges(2);
      rst_n = 1'b1;
      edges(9);
      check("d_u3_out_e9", a_out[3], 4'h0);
      edges(1);
      check("d_u3_out_e10", a_out[3], 4'h3);
      check("d_u3_rise_e10", a_rise[3], EDGE_EN ? 4'h3 : 4'h0);

      // mixed toggling, model-checked every cycle
      for (int i = 0; i < 12; i++) begin
         din = vals[i];
         edges(holds[i]);
      end
      edges(15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
